// File: rtl/lsu_mem_port_if.sv
// Purpose : bundles for the LSU. lsu_req_if carries core request/response traffic
//           (master = core, slave = LSU). lsu_mem_if carries RAM port B traffic
//           (master = LSU, slave = RAM).
// Ports   : req_* / rsp_* on lsu_req_if; mem_* on lsu_mem_if. The _i/_o suffixes
//           are named from the LSU's point of view.
interface lsu_req_if #(parameter int ADDR_WIDTH = 32);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_we_i;
   logic [1:0]            req_size_i;
   logic                  req_signed_i;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [31:0]           req_wdata_i;
   logic                  rsp_valid_o;
   logic [31:0]           rsp_rdata_o;
   logic                  rsp_err_o;

   modport master (output req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i,
                          req_wdata_i,
                   input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
   modport slave  (input  req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i,
                          req_wdata_i,
                   output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
endinterface

interface lsu_mem_if #(parameter int ADDR_WIDTH = 32);
   logic                  mem_valid_o;
   logic                  mem_ready_i;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [31:0]           mem_wdata_o;
   logic [3:0]            mem_we_o;
   logic [31:0]           mem_rdata_i;

   modport master (output mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o,
                   input  mem_ready_i, mem_rdata_i);
   modport slave  (input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o,
                   output mem_ready_i, mem_rdata_i);
endinterface

// File: rtl/lsu_mem_port.sv
// Purpose : load/store unit turning byte/half/word core requests into word-aligned
//           RAM transactions; word-crossing accesses are split into two.
// Latency : 1-cycle RAM: rsp 3 cycles after accept (aligned), 5 (split), 1 (error).
// Backpr. : req_ready_o only in IDLE; waits indefinitely on mem_ready_i.
// Ports   : clk, rst_n (async, active-low); req = core side (slave modport of
//           lsu_req_if); mem = RAM port B (master modport of lsu_mem_if).
module lsu_mem_port #(
   parameter int ADDR_WIDTH       = 32,
   parameter int ALLOW_MISALIGNED = 1
) (
   input  logic      clk,
   input  logic      rst_n,
   lsu_req_if.slave  req,
   lsu_mem_if.master mem
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISS0  = 3'd1,
      S_WAIT0 = 3'd2,
      S_ISS1  = 3'd3,
      S_WAIT1 = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t r_state, w_next;

   // ---------------- request-side alignment arithmetic ----------------
   logic                  w_accept;
   logic [1:0]            w_off;
   logic [3:0]            w_m4;
   logic [7:0]            w_mask8;
   logic [63:0]           w_data64;
   logic                  w_split;
   logic                  w_err;
   logic [ADDR_WIDTH-1:0] w_addr0;

   assign w_accept = req.req_valid_i & (r_state == S_IDLE);
   assign w_off    = req.req_addr_i[1:0];

   always_comb begin
      w_m4 = 4'b1111;
      case (req.req_size_i)
         2'b00:   w_m4 = 4'b0001;
         2'b01:   w_m4 = 4'b0011;
         default: w_m4 = 4'b1111;
      endcase
   end

   assign w_mask8  = {4'b0000, w_m4} << w_off;
   assign w_data64 = {32'h0, req.req_wdata_i} << {w_off, 3'b000};
   assign w_split  = |w_mask8[7:4];
   assign w_err    = (req.req_size_i == 2'b11) | (w_split & (ALLOW_MISALIGNED == 0));
   assign w_addr0  = {req.req_addr_i[ADDR_WIDTH-1:2], 2'b00};

   // ---------------- registered request and bus state ----------------
   logic                  r_we, r_signed, r_split, r_err;
   logic [1:0]            r_size, r_off;
   logic [3:0]            r_we_hi;
   logic [31:0]           r_data_hi;
   logic [ADDR_WIDTH-1:0] r_addr1;
   logic [31:0]           r_lo, r_hi;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [31:0]           r_mem_wdata;
   logic [3:0]            r_mem_we;

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // FSM: next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_err ? S_RESP : S_ISS0;
         S_ISS0:  w_next = S_WAIT0;
         S_WAIT0: if (mem.mem_ready_i) w_next = r_split ? S_ISS1 : S_RESP;
         S_ISS1:  w_next = S_WAIT1;
         S_WAIT1: if (mem.mem_ready_i) w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath. Part 0 bus fields are loaded at acceptance so they are valid in ISS0;
   // part 1 fields are loaded when WAIT0 completes so they are valid in ISS1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we        <= 1'b0;
         r_signed    <= 1'b0;
         r_split     <= 1'b0;
         r_err       <= 1'b0;
         r_size      <= 2'b00;
         r_off       <= 2'b00;
         r_we_hi     <= 4'b0000;
         r_data_hi   <= 32'h0;
         r_addr1     <= '0;
         r_lo        <= 32'h0;
         r_hi        <= 32'h0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'h0;
         r_mem_we    <= 4'b0000;
      end else begin
         if (w_accept) begin
            r_we      <= req.req_we_i;
            r_signed  <= req.req_signed_i;
            r_split   <= w_split;
            r_err     <= w_err;
            r_size    <= req.req_size_i;
            r_off     <= w_off;
            r_we_hi   <= req.req_we_i ? w_mask8[7:4] : 4'b0000;
            r_data_hi <= w_data64[63:32];
            r_addr1   <= w_addr0 + ADDR_WIDTH'(4);   // wraps modulo 2^ADDR_WIDTH
            r_lo      <= 32'h0;
            r_hi      <= 32'h0;                      // stays 0 for non-split loads
            if (!w_err) begin
               r_mem_addr  <= w_addr0;
               r_mem_we    <= req.req_we_i ? w_mask8[3:0] : 4'b0000;
               r_mem_wdata <= w_data64[31:0];
            end
         end
         if ((r_state == S_WAIT0) && mem.mem_ready_i) begin
            r_lo <= mem.mem_rdata_i;
            if (r_split) begin
               r_mem_addr  <= r_addr1;
               r_mem_we    <= r_we_hi;
               r_mem_wdata <= r_data_hi;
            end
         end
         if ((r_state == S_WAIT1) && mem.mem_ready_i) begin
            r_hi <= mem.mem_rdata_i;
         end
      end
   end

   // Load alignment and extension from the captured word pair.
   logic [31:0] w_r;
   logic [31:0] w_ext;

   assign w_r = 32'({r_hi, r_lo} >> {r_off, 3'b000});

   always_comb begin
      w_ext = w_r;
      case (r_size)
         2'b00:   w_ext = {{24{r_signed & w_r[7]}}, w_r[7:0]};
         2'b01:   w_ext = {{16{r_signed & w_r[15]}}, w_r[15:0]};
         default: w_ext = w_r;
      endcase
   end

   // FSM: outputs
   logic        w_req_rdy, w_rsp_vld, w_rsp_err, w_mem_vld;
   logic [31:0] w_rsp_dat;

   always_comb begin
      w_req_rdy = 1'b0;
      w_rsp_vld = 1'b0;
      w_rsp_err = 1'b0;
      w_rsp_dat = 32'h0;
      w_mem_vld = 1'b0;
      case (r_state)
         S_IDLE:  w_req_rdy = 1'b1;
         S_ISS0,
         S_ISS1:  w_mem_vld = 1'b1;
         S_RESP: begin
            w_rsp_vld = 1'b1;
            w_rsp_err = r_err;
            w_rsp_dat = (r_err | r_we) ? 32'h0 : w_ext;
         end
         default: ;
      endcase
   end

   assign req.req_ready_o = w_req_rdy;
   assign req.rsp_valid_o = w_rsp_vld;
   assign req.rsp_err_o   = w_rsp_err;
   assign req.rsp_rdata_o = w_rsp_dat;
   assign mem.mem_valid_o = w_mem_vld;
   assign mem.mem_addr_o  = r_mem_addr;
   assign mem.mem_wdata_o = r_mem_wdata;
   assign mem.mem_we_o    = r_mem_we;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: a table of directed vectors, random traffic against a
// byte-addressed memory model, plus reset-during-WAIT1 and no-misaligned variants.
module tb_lsu_mem_port;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   lsu_req_if #(.ADDR_WIDTH(32)) rq();
   lsu_mem_if #(.ADDR_WIDTH(32)) mm();
   lsu_req_if #(.ADDR_WIDTH(32)) rq2();
   lsu_mem_if #(.ADDR_WIDTH(32)) mm2();

   lsu_mem_port #(.ADDR_WIDTH(32), .ALLOW_MISALIGNED(1)) dut (
      .clk(clk), .rst_n(rst_n), .req(rq.slave), .mem(mm.master));
   lsu_mem_port #(.ADDR_WIDTH(32), .ALLOW_MISALIGNED(0)) dut_na (
      .clk(clk), .rst_n(rst_n), .req(rq2.slave), .mem(mm2.master));

   int nvec = 0;
   int nerr = 0;
   logic sel;    // 0 = dut (split allowed), 1 = dut_na
   int stall;    // extra RAM wait cycles per transaction on dut

   // muxed view of whichever DUT is selected
   wire        v_ready = sel ? rq2.req_ready_o : rq.req_ready_o;
   wire        v_rsp   = sel ? rq2.rsp_valid_o : rq.rsp_valid_o;
   wire [31:0] v_rdata = sel ? rq2.rsp_rdata_o : rq.rsp_rdata_o;
   wire        v_err   = sel ? rq2.rsp_err_o   : rq.rsp_err_o;
   wire        v_mvld  = sel ? mm2.mem_valid_o : mm.mem_valid_o;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // ---------------- RAM model for dut (word array, 1 KB aliased) ----------------
   typedef struct { logic [31:0] a; logic [3:0] we; logic [31:0] wd; } tx_t;
   tx_t         txq[$];
   logic [31:0] ram [0:255];
   int          wcnt;
   bit          pend;
   logic [31:0] paddr;

   always @(negedge clk) begin
      logic [31:0] w;
      mm.mem_ready_i = 1'b0;
      mm.mem_rdata_i = $urandom();            // junk unless ready
      if (!rst_n) begin
         pend = 1'b0;
      end else if (mm.mem_valid_o) begin
         txq.push_back('{mm.mem_addr_o, mm.mem_we_o, mm.mem_wdata_o});
         w = ram[mm.mem_addr_o[9:2]];
         for (int b = 0; b < 4; b++)
            if (mm.mem_we_o[b]) w[8*b +: 8] = mm.mem_wdata_o[8*b +: 8];
         ram[mm.mem_addr_o[9:2]] = w;
         paddr = mm.mem_addr_o;
         pend  = 1'b1;
         wcnt  = stall;
      end else if (pend) begin
         if (wcnt == 0) begin
            mm.mem_ready_i = 1'b1;
            mm.mem_rdata_i = ram[paddr[9:2]];
            pend = 1'b0;
         end else begin
            wcnt--;
         end
      end
   end

   // dut_na RAM: constant word, answers one cycle after valid
   logic na_prev = 1'b0;
   always @(negedge clk) begin
      mm2.mem_ready_i = na_prev;
      mm2.mem_rdata_i = 32'h8BADF00D;
      na_prev = mm2.mem_valid_o & rst_n;
   end

   function automatic logic [31:0] tx_get(input int idx, input int f);
      if (idx >= txq.size()) return 'x;
      case (f)
         0:       return txq[idx].a;
         1:       return {28'h0, txq[idx].we};
         default: return txq[idx].wd;
      endcase
   endfunction

   // ---------------- reference model: byte-addressed memory ----------------
   logic [7:0] mb [0:1023];

   function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic er, output int ntx);
      int n;
      bit split;
      n     = 1 << size;
      split = (int'(addr[1:0]) + n) > 4;
      er    = (size == 2'd3);
      rd    = 32'h0;
      ntx   = er ? 0 : (split ? 2 : 1);
      if (!er) begin
         for (int i = 0; i < n; i++) begin
            if (we) mb[(addr + i) & 32'h3FF] = wd[8*i +: 8];
            else    rd[8*i +: 8] = mb[(addr + i) & 32'h3FF];
         end
         if (!we && sgn && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFFFFFF << (8*n));
      end
   endfunction

   // ---------------- request driver ----------------
   task automatic drive(input bit val, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
      rq.req_valid_i  = val & ~sel;  rq2.req_valid_i  = val & sel;
      rq.req_we_i     = we;          rq2.req_we_i     = we;
      rq.req_size_i   = sz;          rq2.req_size_i   = sz;
      rq.req_signed_i = sg;          rq2.req_signed_i = sg;
      rq.req_addr_i   = a;           rq2.req_addr_i   = a;
      rq.req_wdata_i  = wd;          rq2.req_wdata_i  = wd;
   endtask

   // Issues one request; lat is the cycle of rsp_valid_o counting acceptance as 0.
   // While busy, junk is driven with valid high to show it is ignored.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int ntx, output bit rdy_ok);
      int w;
      bit got;
      w = 0;
      @(negedge clk);
      while (!v_ready && w < 50) begin @(negedge clk); w++; end
      drive(1'b1, we, sz, sg, a, wd);
      @(posedge clk);
      got = 0; ntx = 0; rdy_ok = 1; lat = -1; rd = 'x; er = 'x;
      for (int k = 1; k <= 80 && !got; k++) begin
         @(negedge clk);
         if (v_mvld) ntx++;
         if (v_rsp) begin
            got = 1; lat = k; rd = v_rdata; er = v_err;
            drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
         end else begin
            if (v_ready) rdy_ok = 0;
            drive(1'b1, 1'($urandom()), 2'($urandom()), 1'($urandom()), $urandom(), $urandom());
         end
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic sel; int stall; logic we; logic [1:0] size; logic sgn;
      logic [31:0] addr, wdata, e_rd; logic e_err; int e_lat, e_ntx; bit chk_bus;
      logic [31:0] a0; logic [3:0] we0; logic [31:0] wd0, a1; logic [3:0] we1; logic [31:0] wd1;
   } vec_t;
   vec_t vt[$];

   function automatic vec_t V(logic s, int st, logic we, logic [1:0] sz, logic sg,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] erd, logic eer,
                              int elat, int entx, bit cb, logic [31:0] a0, logic [3:0] we0,
                              logic [31:0] wd0, logic [31:0] a1, logic [3:0] we1,
                              logic [31:0] wd1);
      vec_t v;
      v = '{s, st, we, sz, sg, a, wd, erd, eer, elat, entx, cb, a0, we0, wd0, a1, we1, wd1};
      return v;
   endfunction

   initial begin
      logic [31:0] rd, erd;
      logic er, eer;
      int lat, ntx, entx, elat;
      bit rdy_ok, seen;

      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, erd;
      logic er, eer;
      int lat, ntx, entx, elat;
      bit rdy_ok, seen;
      vec_t v;

      rst_n = 1'b0; sel = 1'b0; stall = 0;
      mm.mem_ready_i = 1'b0; mm.mem_rdata_i = 32'h0;
      mm2.mem_ready_i = 1'b0; mm2.mem_rdata_i = 32'h0;
      drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      for (int i = 0; i < 1024; i++) mb[i] = 8'h0;

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", rq.req_ready_o, 1);
      chk("rst_rsp_valid", rq.rsp_valid_o, 0);
      chk("rst_rsp_err",   rq.rsp_err_o, 0);
      chk("rst_rsp_rdata", rq.rsp_rdata_o, 0);
      chk("rst_mem_valid", mm.mem_valid_o, 0);
      chk("rst_mem_addr",  mm.mem_addr_o, 0);
      chk("rst_mem_wdata", mm.mem_wdata_o, 0);
      chk("rst_mem_we",    mm.mem_we_o, 0);
      rst_n = 1'b1;

      //        sel st we sz sg addr          wdata         e_rd          err lat ntx bus a0            we0    wd0           a1            we1    wd1
      vt.push_back(V(0, 0, 1, 2, 0, 32'h100,      32'hDEADBEEF, 32'h0,        0, 3, 1, 1, 32'h100,      4'hF, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0));
      vt.push_back(V(0, 0, 0, 2, 0, 32'h100,      32'h0,        32'hDEADBEEF, 0, 3, 1, 1, 32'h100,      4'h0, 32'h0,        32'h0, 4'h0, 32'h0));
      vt.push_back(V(0, 0, 1, 0, 0, 32'h103,      32'h000000A5, 32'h0,        0, 3, 1, 1, 32'h100,      4'h8, 32'hA5000000, 32'h0, 4'h0, 32'h0));
      vt.push_back(V(0, 0, 0, 0, 1, 32'h103,      32'h0,        32'hFFFFFFA5, 0, 3, 1, 1, 32'h100,      4'h0, 32'h0,        32'h0, 4'h0, 32'h0));
      vt.push_back(V(0, 0, 0, 0, 0, 32'h103,      32'h0,        32'h000000A5, 0, 3, 1, 1, 32'h100,      4'h0, 32'h0,        32'h0, 4'h0, 32'h0));
      vt.push_back(V(0, 0, 1, 2, 0, 32'h201,      32'h11223344, 32'h0,        0, 5, 2, 1, 32'h200,      4'hE, 32'h22334400, 32'h204, 4'h1, 32'h00000011));
      vt.push_back(V(0, 0, 0, 2, 0, 32'h201,      32'h0,        32'h11223344, 0, 5, 2, 1, 32'h200,      4'h0, 32'h0,        32'h204, 4'h0, 32'h0));
      vt.push_back(V(0, 4, 0, 2, 0, 32'h100,      32'h0,        32'hA5ADBEEF, 0, 7, 1, 1, 32'h100,      4'h0, 32'h0,        32'h0, 4'h0, 32'h0));
      vt.push_back(V(0, 0, 1, 3, 0, 32'h40,       32'h12345678, 32'h0,        1, 1, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0, 4'h0, 32'h0));
      vt.push_back(V(0, 0, 0, 3, 1, 32'h41,       32'h0,        32'h0,        1, 1, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0, 4'h0, 32'h0));
      vt.push_back(V(0, 0, 1, 1, 0, 32'h3FF,      32'h0000BEEF, 32'h0,        0, 5, 2, 1, 32'h3FC,      4'h8, 32'hEF000000, 32'h400, 4'h1, 32'h000000BE));
      vt.push_back(V(0, 0, 0, 1, 1, 32'h3FF,      32'h0,        32'hFFFFBEEF, 0, 5, 2, 1, 32'h3FC,      4'h0, 32'h0,        32'h400, 4'h0, 32'h0));
      vt.push_back(V(0, 0, 1, 2, 0, 32'hFFFFFFFE, 32'hCAFEF00D, 32'h0,        0, 5, 2, 1, 32'hFFFFFFFC, 4'hC, 32'hF00D0000, 32'h0, 4'h3, 32'h0000CAFE));
      vt.push_back(V(0, 0, 0, 2, 0, 32'hFFFFFFFE, 32'h0,        32'hCAFEF00D, 0, 5, 2, 1, 32'hFFFFFFFC, 4'h0, 32'h0,        32'h0, 4'h0, 32'h0));
      vt.push_back(V(0, 0, 0, 1, 1, 32'h101,      32'h0,        32'hFFFFADBE, 0, 3, 1, 1, 32'h100,      4'h0, 32'h0,        32'h0, 4'h0, 32'h0));
      vt.push_back(V(0, 0, 1, 1, 0, 32'h202,      32'h00001234, 32'h0,        0, 3, 1, 1, 32'h200,      4'hC, 32'h12340000, 32'h0, 4'h0, 32'h0));
      vt.push_back(V(0, 0, 0, 0, 1, 32'h203,      32'h0,        32'h00000012, 0, 3, 1, 1, 32'h200,      4'h0, 32'h0,        32'h0, 4'h0, 32'h0));
      vt.push_back(V(1, 0, 0, 1, 0, 32'h0FF,      32'h0,        32'h0,        1, 1, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0, 4'h0, 32'h0));
      vt.push_back(V(1, 0, 0, 2, 0, 32'h100,      32'h0,        32'h8BADF00D, 0, 3, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0, 4'h0, 32'h0));
      vt.push_back(V(1, 0, 0, 1, 0, 32'h101,      32'h0,        32'h0000ADF0, 0, 3, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0, 4'h0, 32'h0));
      vt.push_back(V(1, 0, 1, 2, 0, 32'h102,      32'hFFFFFFFF, 32'h0,        1, 1, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0, 4'h0, 32'h0));
      vt.push_back(V(1, 0, 0, 3, 1, 32'h104,      32'h0,        32'h0,        1, 1, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0, 4'h0, 32'h0));

      foreach (vt[i]) begin
         v = vt[i];
         sel = v.sel; stall = v.stall;
         txq.delete();
         if (!v.sel) model(v.we, v.size, v.sgn, v.addr, v.wdata, erd, eer, entx);
         do_req(v.we, v.size, v.sgn, v.addr, v.wdata, rd, er, lat, ntx, rdy_ok);
         chk($sformatf("v%0d_rdata", i), rd, v.e_rd);
         chk($sformatf("v%0d_err", i), er, v.e_err);
         chk($sformatf("v%0d_lat", i), lat, v.e_lat);
         chk($sformatf("v%0d_ntx", i), ntx, v.e_ntx);
         chk($sformatf("v%0d_busy", i), rdy_ok, 1);
         if (v.chk_bus) begin
            chk($sformatf("v%0d_addr0", i), tx_get(0, 0), v.a0);
            chk($sformatf("v%0d_we0", i), tx_get(0, 1), {28'h0, v.we0});
            if (v.we) chk($sformatf("v%0d_wd0", i), tx_get(0, 2), v.wd0);
            if (v.e_ntx == 2) begin
               chk($sformatf("v%0d_addr1", i), tx_get(1, 0), v.a1);
               chk($sformatf("v%0d_we1", i), tx_get(1, 1), {28'h0, v.we1});
               if (v.we) chk($sformatf("v%0d_wd1", i), tx_get(1, 2), v.wd1);
            end
         end
      end

      // ---------------- randomized traffic vs byte model ----------------
      sel = 1'b0;
      for (int i = 0; i < 250; i++) begin
         logic        rwe, rsg;
         logic [1:0]  rsz;
         logic [31:0] ra, rwd;
         rwe = 1'($urandom());
         rsg = 1'($urandom());
         rsz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         ra  = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) == 0) ra = ra | 32'hFFFFFC00;
         rwd = $urandom();
         stall = $urandom_range(0, 2);
         model(rwe, rsz, rsg, ra, rwd, erd, eer, entx);
         elat = eer ? 1 : ((entx == 2 ? 5 : 3) + stall * entx);
         do_req(rwe, rsz, rsg, ra, rwd, rd, er, lat, ntx, rdy_ok);
         chk($sformatf("r%0d_rdata", i), rd, erd);
         chk($sformatf("r%0d_err", i), er, eer);
         chk($sformatf("r%0d_lat", i), lat, elat);
         chk($sformatf("r%0d_ntx", i), ntx, entx);
      end

      // ---------------- reset asserted during WAIT1 of a split load ----------------
      sel = 1'b0; stall = 0;
      @(negedge clk);
      drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h201, 32'h0);
      @(posedge clk);
      @(negedge clk);                 // cycle 1: ISS0
      drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);                 // cycle 2: WAIT0, RAM answers
      stall = 20;                     // part 1 will not be answered
      @(negedge clk);                 // cycle 3: ISS1
      chk("rst_mid_iss1", mm.mem_valid_o, 1);
      @(negedge clk);                 // cycle 4: WAIT1
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_valid", mm.mem_valid_o, 0);
      chk("rst_mid_req_ready", rq.req_ready_o, 1);
      chk("rst_mid_rsp_valid", rq.rsp_valid_o, 0);
      seen = 0;
      repeat (2) begin @(negedge clk); if (rq.rsp_valid_o) seen = 1; end
      rst_n = 1'b1;
      repeat (6) begin @(negedge clk); if (rq.rsp_valid_o || mm.mem_valid_o) seen = 1; end
      chk("rst_mid_no_rsp", seen, 0);
      stall = 0;
      model(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, erd, eer, entx);
      do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er, lat, ntx, rdy_ok);
      chk("post_rst_rdata", rd, erd);
      chk("post_rst_err", er, 0);
      chk("post_rst_lat", lat, 3);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit that converts core data requests into word-granular transactions on one port of the dual-port data RAM.
- Handles byte, halfword and word sizes, byte-enable generation, and store-data lane shifting.
- Loads are aligned and sign- or zero-extended.
- Misaligned accesses that cross a word boundary are split into two back-to-back RAM transactions.
- Sits between the core execute/memory stage and RAM port B.

Parameters:
ADDR_WIDTH, 32 (`RISCV_ADDR_WIDTH), byte address width
ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses; 0 = answer them with an error, no RAM access

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid_i  in  1  core request valid
req_ready_o  out  1  LSU can accept a request
req_we_i  in  1  1 = store, 0 = load
req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed_i  in  1  loads: 1 = sign-extend, 0 = zero-extend
req_addr_i  in  ADDR_WIDTH  byte address
req_wdata_i  in  32  store data, right-justified
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  32  extended load data; 0 for stores and errors
rsp_err_o  out  1  illegal size, or misaligned with ALLOW_MISALIGNED=0
mem_valid_o  out  1  RAM request, one-cycle pulse per transaction
mem_ready_i  in  1  RAM completion; rdata is valid in the same cycle
mem_addr_o  out  ADDR_WIDTH  word-aligned address, [1:0]=00
mem_wdata_o  out  32  lane-shifted store data
mem_we_o  out  4  byte write enables; 0000 for loads
mem_rdata_i  in  32  RAM read word

Behaviour:
- Reset values: req_ready_o=1; rsp_valid_o=0; rsp_err_o=0; rsp_rdata_o=0; mem_valid_o=0; mem_addr_o=0; mem_wdata_o=0; mem_we_o=0; FSM=IDLE.
- Acceptance:
  - req_ready_o=1 only in IDLE.
  - A request is accepted on a clock edge where req_valid_i & req_ready_o.
  - All request fields are registered at acceptance.
- Alignment arithmetic:
  - off = addr[1:0].
  - mask8 = {4'b0,M} << off, where M = 0001 (byte), 0011 (half), 1111 (word).
  - data64 = {32'b0,wdata} << (8*off).
  - split = mask8[7:4] != 0.
- Address, enables and data:
  - Part 0: addr {addr[W-1:2],2'b00}, we=mask8[3:0], wdata=data64[31:0].
  - Part 1: address = part-0 address + 4, wrapping modulo 2^ADDR_WIDTH; we=mask8[7:4], wdata=data64[63:32].
  - Loads drive we=0000.
- FSM states: IDLE, ISS0, WAIT0, ISS1, WAIT1, RESP.
  - IDLE -> ISS0 on accept.
  - IDLE -> RESP directly (error, no RAM traffic) if size=11, or if split with ALLOW_MISALIGNED=0.
  - ISS0: mem_valid_o=1 for exactly one cycle -> WAIT0.
  - WAIT0: on mem_ready_i, capture mem_rdata_i into lo; go to ISS1 if split, else RESP. Waits indefinitely otherwise.
  - ISS1 -> WAIT1.
  - WAIT1: on mem_ready_i, capture into hi -> RESP.
  - RESP: rsp_valid_o=1 for one cycle -> IDLE.
- mem_addr_o, mem_wdata_o and mem_we_o are registered, valid in ISS cycles, and held until the next ISS.
- mem_ready_i is ignored outside WAIT0/WAIT1.
- Load result:
  - r = ({hi,lo} >> 8*off) [31:0]; hi=0 when there is no split.
  - Byte: r[7:0] extended. Half: r[15:0] extended. Word: r.
  - Extension is per req_signed_i.
- Latency with a RAM that answers one cycle after valid (acceptance = cycle 0):
  - Aligned: mem_valid_o in cycle 1, mem_ready_i in cycle 2, rsp_valid_o in cycle 3, next accept possible in cycle 4.
  - Split: second mem_valid_o in cycle 3, rsp_valid_o in cycle 5.
  - Error: rsp_valid_o in cycle 1.
- Reset mid-operation:
  - Outputs drop to reset values asynchronously and the response is lost.
  - A RAM write already sampled may still complete; this is accepted.
- req_valid_i held while not ready: no effect. Fields may change freely until accepted.

Test Plan:
- Word store 0xDEADBEEF @0x100, then word load @0x100 -> part 0 addr 0x100, we=1111; load rsp_rdata_o=0xDEADBEEF, rsp_valid_o in cycle 3, rsp_err_o=0.
- Byte store 0x000000A5 @0x103, then signed byte load @0x103 -> we=1000, mem_wdata_o=0xA5000000; load response 0xFFFFFFA5. Unsigned load of the same byte -> 0x000000A5.
- Word store 0x11223344 @0x201 (ALLOW_MISALIGNED=1) -> two transactions:
  - addr 0x200, we=1110, wdata=0x22334400;
  - addr 0x204, we=0001, wdata=0x00000011;
  - word load @0x201 returns 0x11223344 with rsp_valid_o in cycle 5.
- Half load @0x0FF with ALLOW_MISALIGNED=0, and any request with size=11 -> no mem_valid_o; rsp_valid_o in cycle 1 with rsp_err_o=1, rsp_rdata_o=0.
- RAM stalls mem_ready_i for 4 cycles -> FSM holds in WAIT0; mem_valid_o pulsed only once; req_ready_o=0 throughout; correct data after ready.
- Assert rst_n low during WAIT1 of a split load -> mem_valid_o=0 and req_ready_o=1 immediately; no rsp_valid_o. A new aligned load after reset completes normally.
